// File: rtl/seg7_pkg.sv
// Shared types and helpers for the seg7 scan controller.
//   scan_state_t : BLANK (all anodes off) / SHOW (one digit lit)
//   SEG_OFF      : g..a pattern with every segment dark
//   SEG_MINUS    : g..a pattern for a lone minus sign (reserved)
//   an_onehot()  : one-hot anode pattern for a digit index, optionally inverted
package seg7_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_OFF   = 7'h00;
  localparam logic [6:0] SEG_MINUS = 7'h40;

  // Eight bits covers the largest supported display; callers keep the low
  // NUM_DIGITS bits.
  function automatic logic [7:0] an_onehot(input logic [2:0] idx, input logic active_low);
    logic [7:0] oh;
    oh = 8'b1 << idx;
    return active_low ? ~oh : oh;
  endfunction

endpackage

// File: rtl/seg7_lz_mask.sv
// Leading-zero mask for the scan controller.
//   value_i : NUM_DIGITS packed nibbles, digit 0 in bits [3:0]
//   en_i    : blanking enable
//   blank_o : bit i set when digit i and every more-significant digit are 0;
//             digit 0 is never blanked so a zero value still shows "0"
module seg7_lz_mask #(
  parameter int NUM_DIGITS = 4
) (
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic                    en_i,
  output logic [NUM_DIGITS-1:0]   blank_o
);

  logic zero_above;

  always_comb begin
    zero_above = 1'b1;
    blank_o    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above & (value_i[4*i +: 4] == 4'h0);
      if (i != 0) blank_o[i] = en_i & zero_above;
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit 7-segment display that
// shares one external hex decoder between all digits.
//   clk, rst   : clock, asynchronous active-high reset
//   value_in   : packed nibbles, digit 0 (rightmost) in [3:0]
//   load       : strobe capturing value_in / blank_lz / dp_mask into pending
//   blank_lz   : leading-zero blanking enable, captured with the value
//   dp_mask    : decimal-point enables, one per digit
//   load_ack   : pulse when the pending value is committed (frame boundary)
//   frame_done : pulse at the end of the last digit's SHOW slot
//   digit_hex  : nibble for the external decoder, seg_in: its g..a result
//   seg_out    : registered {dp, g..a}; an: registered digit enables
//
// state | meaning
// BLANK | all anodes off for BLANK_CYC cycles before the next digit
// SHOW  | anode idx lit for SHOW_CYC cycles
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SHOW_CYC       = 50000,
  parameter int BLANK_CYC      = 500,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic                    load_ack,
  output logic                    frame_done,
  output logic [3:0]              digit_hex,
  input  logic [6:0]              seg_in,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int MAX_CYC = (SHOW_CYC > BLANK_CYC) ? SHOW_CYC : BLANK_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0]      SHOW_TC  = CNT_W'(SHOW_CYC - 1);
  localparam logic [CNT_W-1:0]      BLANK_TC = CNT_W'(BLANK_CYC - 1);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = (AN_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [7:0]            SEG_INV  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  scan_state_t              state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0]  disp_q, disp_d, pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0]    dp_disp_q, dp_disp_d, pend_dp_q, pend_dp_d;
  logic                     blz_disp_q, blz_disp_d, pend_blz_q, pend_blz_d;
  logic                     pend_q, pend_d;
  logic [7:0]               seg_q, seg_d;
  logic [NUM_DIGITS-1:0]    an_q, an_d;

  logic                     term;
  logic                     frame_end;
  logic                     commit;
  logic [NUM_DIGITS-1:0]    blank_vec;
  logic [7:0]               an_sel;

  seg7_lz_mask #(.NUM_DIGITS(NUM_DIGITS)) u_lz_mask (
    .value_i (disp_q),
    .en_i    (blz_disp_q),
    .blank_o (blank_vec)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    idx_d      = idx_q;
    disp_d     = disp_q;
    dp_disp_d  = dp_disp_q;
    blz_disp_d = blz_disp_q;
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    pend_blz_d = pend_blz_q;
    pend_d     = pend_q;

    term      = (state_q == SHOW) ? (cnt_q == SHOW_TC) : (cnt_q == BLANK_TC);
    frame_end = (state_q == SHOW) && term && (idx_q == LAST_IDX);
    commit    = frame_end && (pend_q || load);

    if (term) begin
      cnt_d = '0;
      if (state_q == BLANK) begin
        state_d = SHOW;
      end else begin
        state_d = BLANK;
        idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      end
    end

    if (load) begin
      pend_val_d = value_in;
      pend_dp_d  = dp_mask;
      pend_blz_d = blank_lz;
      pend_d     = 1'b1;
    end

    // A load landing on the boundary bypasses pending and goes straight up.
    if (commit) begin
      disp_d     = load ? value_in : pend_val_q;
      dp_disp_d  = load ? dp_mask  : pend_dp_q;
      blz_disp_d = load ? blank_lz : pend_blz_q;
      pend_d     = 1'b0;
    end

    seg_d = (blank_vec[idx_q] ? {1'b0, SEG_OFF} : {dp_disp_q[idx_q], seg_in}) ^ SEG_INV;

    an_sel = an_onehot(3'(idx_q), AN_ACTIVE_LOW != 0);
    an_d   = (state_q == SHOW) ? an_sel[NUM_DIGITS-1:0] : AN_OFF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BLANK;
      cnt_q      <= '0;
      idx_q      <= '0;
      disp_q     <= '0;
      dp_disp_q  <= '0;
      blz_disp_q <= 1'b0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      pend_blz_q <= 1'b0;
      pend_q     <= 1'b0;
      seg_q      <= {1'b0, SEG_OFF} ^ SEG_INV;
      an_q       <= AN_OFF;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      disp_q     <= disp_d;
      dp_disp_q  <= dp_disp_d;
      blz_disp_q <= blz_disp_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      pend_blz_q <= pend_blz_d;
      pend_q     <= pend_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign digit_hex  = disp_q[4*idx_q +: 4];
  assign frame_done = frame_end;
  assign load_ack   = commit;
  assign seg_out    = seg_q;
  assign an         = an_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: 4 digits, SHOW=4, BLANK=1, active-low anodes.
// Expected digit patterns are queued per frame and compared when each digit
// first lights up.
module tb_seg7_scan_ctrl;

  typedef struct {
    logic [3:0] an;
    logic [7:0] seg;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value_in = 16'h0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [3:0]  dp_mask = 4'h0;
  logic        load_ack, frame_done;
  logic [3:0]  digit_hex;
  logic [6:0]  seg_in;
  logic [7:0]  seg_out;
  logic [3:0]  an;

  int   n_chk = 0;
  int   n_fail = 0;
  int   ack_cnt = 0;
  int   ack_base;
  logic [3:0] prev_an = 4'hF;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  assign seg_in = hex7(digit_hex);

  seg7_scan_ctrl #(
    .NUM_DIGITS(4), .SHOW_CYC(4), .BLANK_CYC(1), .AN_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst(rst), .value_in(value_in), .load(load), .blank_lz(blank_lz),
    .dp_mask(dp_mask), .load_ack(load_ack), .frame_done(frame_done),
    .digit_hex(digit_hex), .seg_in(seg_in), .seg_out(seg_out), .an(an)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Digit d blanks when it and all higher digits are zero (never digit 0).
  function automatic logic [7:0] exp_seg(input logic [15:0] v, input logic blz,
                                         input logic [3:0] dpm, input int d);
    logic [15:0] upper;
    upper = v >> (4 * d);
    if (blz && d != 0 && upper == 16'h0) return 8'h00;
    return {dpm[d], hex7(upper[3:0])};
  endfunction

  function automatic logic [3:0] exp_an(input int k);
    logic [3:0] one;
    one = 4'b0001;
    if (k % 5 == 0) return 4'hF;
    return ~(one << (k / 5));
  endfunction

  task automatic push_frame(input logic [15:0] v, input logic blz, input logic [3:0] dpm);
    exp_t e;
    logic [3:0] one;
    one = 4'b0001;
    for (int d = 0; d < 4; d++) begin
      e.an  = ~(one << d);
      e.seg = exp_seg(v, blz, dpm, d);
      sb_q.push_back(e);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic blz, input logic [3:0] dpm);
    value_in = v;
    blank_lz = blz;
    dp_mask  = dpm;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < 60);
    if (frame_done !== 1'b1) check_eq("frame_timeout", frame_done, 1);
  endtask

  // Scoreboard consumer: compares on the first lit cycle of each digit.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (an !== 4'hF && prev_an === 4'hF && sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("digit_seg", seg_out, e.seg);
        check_eq("digit_an", an, e.an);
      end
      if (load_ack === 1'b1) begin
        ack_cnt++;
        check_eq("ack_with_fd", frame_done, 1);
      end
    end
    prev_an = an;
  end

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check_eq("rst_an", an, 4'hF);
    check_eq("rst_seg", seg_out, 8'h00);
    check_eq("rst_hex", digit_hex, 4'h0);
    check_eq("rst_ack", load_ack, 0);
    check_eq("rst_fd", frame_done, 0);

    // 1: free-running scan of zeros
    push_frame(16'h0, 1'b0, 4'h0);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check_eq("scan_an", an, exp_an(k));
      check_eq("scan_fd", frame_done, (k == 18) ? 1 : 0);
    end

    // 2: mid-frame load stays hidden until the boundary
    push_frame(16'h0, 1'b0, 4'h0);
    repeat (8) @(negedge clk);
    do_load(16'h12AF, 1'b0, 4'b0100);
    wait_frame();
    check_eq("ack_t2", load_ack, 1);
    push_frame(16'h12AF, 1'b0, 4'b0100);

    // 3: leading-zero blanking with a suppressed dp
    repeat (5) @(negedge clk);
    do_load(16'h0050, 1'b1, 4'b1000);
    wait_frame();
    check_eq("ack_t3", load_ack, 1);
    push_frame(16'h0050, 1'b1, 4'b1000);

    // 4: two loads in a frame, one ack
    repeat (4) @(negedge clk);
    do_load(16'h1111, 1'b0, 4'h0);
    repeat (4) @(negedge clk);
    do_load(16'h2222, 1'b0, 4'h0);
    ack_base = ack_cnt;
    wait_frame();
    check_eq("ack_t4", load_ack, 1);
    @(negedge clk);
    #3;
    check_eq("ack_once_t4", ack_cnt - ack_base, 1);
    push_frame(16'h2222, 1'b0, 4'h0);

    // 5: load on the boundary cycle itself
    wait_frame();
    check_eq("ack_pre_bnd", load_ack, 0);
    value_in = 16'h000F;
    blank_lz = 1'b0;
    dp_mask  = 4'h0;
    load     = 1'b1;
    #1;
    check_eq("ack_on_bnd", load_ack, 1);
    check_eq("fd_on_bnd", frame_done, 1);
    @(negedge clk);
    load = 1'b0;
    push_frame(16'h000F, 1'b0, 4'h0);

    // 6: reset during SHOW of digit 2 with a load still pending
    repeat (3) @(negedge clk);
    do_load(16'h1234, 1'b0, 4'hF);
    repeat (8) @(negedge clk);
    check_eq("pre_rst_an", an, 4'b1011);
    #3;
    rst = 1'b1;
    #1;
    check_eq("arst_an", an, 4'hF);
    check_eq("arst_seg", seg_out, 8'h00);
    check_eq("arst_hex", digit_hex, 4'h0);
    check_eq("arst_fd", frame_done, 0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    push_frame(16'h0, 1'b0, 4'h0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_eq("restart_an", an, exp_an(k));
    end
    wait_frame();
    check_eq("no_ack_after_rst", load_ack, 0);
    repeat (3) @(negedge clk);

    check_eq("sb_drained", sb_q.size(), 0);
    check_eq("ack_total", ack_cnt, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
